// File: rtl/cdb_pkg.sv
// Shared CDB definitions: default sizes and the bus packet
// seen by the ROB and reservation-station consumers.
package cdb_pkg;

  localparam int CDB_NUM_REQ = 4;
  localparam int CDB_DATA_W  = 32;
  localparam int CDB_TAG_W   = 6;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_pkt_t;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set req at or above ptr wins.
// Ports: req, ptr in; gnt (one-hot), idx (binary), any out.
module rr_pick #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx,
  output logic          any
);

  logic [SW-1:0] j;

  // Walk offsets high to low so the nearest match to ptr lands last.
  // N is a power of two, so SW-bit addition is the modulo wrap.
  always_comb begin
    j   = ptr;
    idx = ptr;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = ptr + SW'(k);
      if (req[j]) begin
        idx = j;
        any = 1'b1;
      end
    end
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Round-robin CDB arbiter: grants one producer per cycle and
// registers its result onto the bus (clk, reset, flush, req_*, cdb_*).
module cdb_rr_arbiter
  import cdb_pkg::*;
#(
  parameter  int NUM_REQ = CDB_NUM_REQ,
  parameter  int DATA_W  = CDB_DATA_W,
  parameter  int TAG_W   = CDB_TAG_W,
  localparam int SEL_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [SEL_W-1:0]          cdb_sel,
  output logic                      cdb_valid,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [SEL_W-1:0]          cdb_src
);

  logic [SEL_W-1:0]   ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   idx;
  logic               any;
  logic               xfer;

  rr_pick #(
    .N  (NUM_REQ),
    .SW (SEL_W)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  assign xfer      = any & ~flush;
  assign req_ready = flush ? '0 : gnt;
  assign cdb_sel   = idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      cdb_valid <= 1'b0;
      cdb_data  <= '0;
      cdb_tag   <= '0;
      cdb_src   <= '0;
    end else if (xfer) begin
      ptr       <= idx + SEL_W'(1);
      cdb_valid <= 1'b1;
      cdb_data  <= req_data[idx*DATA_W +: DATA_W];
      cdb_tag   <= req_tag[idx*TAG_W +: TAG_W];
      cdb_src   <= idx;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule
